// File: rtl/clksw_pkg.sv
// Shared types and defaults for the fast/host clock-switch initiator.
// State encoding plus the output decode used by the FSM.
package clksw_pkg;

  typedef enum logic [1:0] {
    ST_LS    = 2'd0,
    ST_TO_HS = 2'd1,
    ST_HS    = 2'd2,
    ST_TO_LS = 2'd3
  } clksw_state_e;

  localparam int DEF_SYNC    = 2;
  localparam int DEF_HOLDOFF = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_TMR_W   = 8;

  typedef struct packed {
    logic sel;
    logic ls_act;
    logic hs_act;
    logic busy;
  } clksw_out_t;

  function automatic clksw_out_t state_outs(
    input clksw_state_e s
  );
    clksw_out_t o;
    o.sel    = (s == ST_TO_HS) || (s == ST_HS);
    o.ls_act = (s == ST_LS);
    o.hs_act = (s == ST_HS);
    o.busy   = (s == ST_TO_HS) || (s == ST_TO_LS);
    return o;
  endfunction

endpackage

// File: rtl/clksw_sync.sv
// N-flop synchroniser for the asynchronous clock-switch acknowledges.
// Reset value is a parameter so each chain can idle in its LS polarity.
module clksw_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      ff <= {N{RST_VAL}};
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/clksw_initiator.sv
// Initiator side of the HS/LS CPU clock-switch handshake.
// Requests the fast clock when allowed and idle, falls back for host access.
module clksw_initiator
  import clksw_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC,
  parameter int HOLDOFF     = DEF_HOLDOFF,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TMR_W       = DEF_TMR_W
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic hs_allow,
  input  logic host_access_req,
  input  logic hsclk_selected,
  input  logic lsclk_selected,
  input  logic err_clr,
  output logic hsclk_sel,
  output logic ls_active,
  output logic hs_active,
  output logic switch_busy,
  output logic timeout_err
);

  localparam logic [TMR_W-1:0] HOLD_V = TMR_W'(HOLDOFF);
  localparam logic [TMR_W-1:0] TO_V   = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] ONE    = TMR_W'(1);

  clksw_state_e     state;
  clksw_out_t       o_q;
  logic [TMR_W-1:0] cnt;
  logic             hs_ack;
  logic             ls_ack;
  logic             hs_ok;
  logic             ls_ok;
  logic             want_hs;
  logic             cnt_zero;
  logic             to_event;

  clksw_sync #(
    .N       (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_hs_sync (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (hsclk_selected),
    .q        (hs_ack)
  );

  clksw_sync #(
    .N       (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ls_sync (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (lsclk_selected),
    .q        (ls_ack)
  );

  // Both acks equal means the controller is mid-handover: not acked.
  assign hs_ok    = hs_ack & ~ls_ack;
  assign ls_ok    = ls_ack & ~hs_ack;
  assign want_hs  = hs_allow & ~host_access_req;
  assign cnt_zero = (cnt == '0);

  // Fires once, on the 1->0 step, so a cleared error stays cleared.
  assign to_event = (cnt == ONE) &&
    (((state == ST_TO_HS) && !hs_ok) ||
     ((state == ST_TO_LS) && !ls_ok));

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state       <= ST_LS;
      o_q         <= state_outs(ST_LS);
      cnt         <= HOLD_V;
      timeout_err <= 1'b0;
    end else begin
      if (to_event) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      unique case (state)
        ST_LS: begin
          if (!want_hs) begin
            cnt <= HOLD_V;
          end else if (!cnt_zero) begin
            cnt <= cnt - ONE;
          end else begin
            state <= ST_TO_HS;
            o_q   <= state_outs(ST_TO_HS);
            cnt   <= TO_V;
          end
        end
        ST_TO_HS: begin
          if (hs_ok) begin
            state <= ST_HS;
            o_q   <= state_outs(ST_HS);
          end else if (!cnt_zero) begin
            cnt <= cnt - ONE;
          end
        end
        ST_HS: begin
          if (!want_hs) begin
            state <= ST_TO_LS;
            o_q   <= state_outs(ST_TO_LS);
            cnt   <= TO_V;
          end
        end
        ST_TO_LS: begin
          if (ls_ok) begin
            state <= ST_LS;
            o_q   <= state_outs(ST_LS);
            cnt   <= HOLD_V;
          end else if (!cnt_zero) begin
            cnt <= cnt - ONE;
          end
        end
      endcase
    end
  end

  assign hsclk_sel   = o_q.sel;
  assign ls_active   = o_q.ls_act;
  assign hs_active   = o_q.hs_act;
  assign switch_busy = o_q.busy;

endmodule

// File: tb/tb_clksw_initiator.sv
// Bench for clksw_initiator: delayed-ack controller model plus a
// cycle scoreboard, with directed latency checks on top.
module tb_clksw_initiator;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int TMO  = 255;
  localparam int CDLY = 3;

  logic hsclk_in        = 1'b0;
  logic rst_b           = 1'b0;
  logic hs_allow        = 1'b1;
  logic host_access_req = 1'b0;
  logic err_clr         = 1'b0;
  logic hsclk_selected;
  logic lsclk_selected;
  logic hsclk_sel;
  logic ls_active;
  logic hs_active;
  logic switch_busy;
  logic timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 hsclk_in = ~hsclk_in;

  clksw_initiator #(
    .SYNC_STAGES (SYNC),
    .HOLDOFF     (HOLD),
    .TIMEOUT     (TMO),
    .TMR_W       (8)
  ) dut (
    .hsclk_in        (hsclk_in),
    .rst_b           (rst_b),
    .hs_allow        (hs_allow),
    .host_access_req (host_access_req),
    .hsclk_selected  (hsclk_selected),
    .lsclk_selected  (lsclk_selected),
    .err_clr         (err_clr),
    .hsclk_sel       (hsclk_sel),
    .ls_active       (ls_active),
    .hs_active       (hs_active),
    .switch_busy     (switch_busy),
    .timeout_err     (timeout_err)
  );

  // Controller: acks follow hsclk_sel after CDLY cycles.
  logic [CDLY-1:0] ctl_d;
  logic ctl_mute = 1'b0;
  logic ctl_both = 1'b0;
  logic ctl_drop = 1'b0;

  always @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) ctl_d <= '0;
    else if (!ctl_mute) ctl_d <= {ctl_d[CDLY-2:0], hsclk_sel};
  end

  assign hsclk_selected = (ctl_d[CDLY-1] | ctl_both) & ~ctl_drop;
  assign lsclk_selected = ~ctl_d[CDLY-1] | ctl_both;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: state 0=LS 1=TO_HS 2=HS 3=TO_LS.
  logic [4:0]      exp_q[$];
  int              m_st;
  int              m_cnt;
  bit              m_err;
  bit              m_ev;
  bit              m_hok;
  bit              m_lok;
  bit              m_want;
  logic [SYNC-1:0] m_hs;
  logic [SYNC-1:0] m_ls;

  function automatic logic [4:0] exp_of(input int st, input bit err);
    return {st == 1 || st == 2, st == 0, st == 2,
            st == 1 || st == 3, err};
  endfunction

  always @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      m_st  = 0;
      m_cnt = HOLD;
      m_err = 0;
      m_hs  = '0;
      m_ls  = '1;
      if (!hsclk_in || $time == 0) exp_q.delete();
      exp_q.delete();
      exp_q.push_back(exp_of(m_st, m_err));
    end else begin
      m_hok  = m_hs[SYNC-1] && !m_ls[SYNC-1];
      m_lok  = m_ls[SYNC-1] && !m_hs[SYNC-1];
      m_want = hs_allow && !host_access_req;
      m_ev   = 0;
      if (m_st == 0) begin
        if (!m_want) m_cnt = HOLD;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin m_st = 1; m_cnt = TMO; end
      end else if (m_st == 2) begin
        if (!m_want) begin m_st = 3; m_cnt = TMO; end
      end else if ((m_st == 1 && m_hok) || (m_st == 3 && m_lok)) begin
        m_cnt = (m_st == 3) ? HOLD : m_cnt;
        m_st  = (m_st == 1) ? 2 : 0;
      end else if (m_cnt > 0) begin
        m_ev  = (m_cnt == 1);
        m_cnt = m_cnt - 1;
      end
      if (m_ev) m_err = 1;
      else if (err_clr) m_err = 0;
      m_hs = {m_hs[SYNC-2:0], hsclk_selected};
      m_ls = {m_ls[SYNC-2:0], lsclk_selected};
      exp_q.push_back(exp_of(m_st, m_err));
    end
  end

  always @(negedge hsclk_in) begin
    if (exp_q.size() > 0)
      chk("sb", 32'({hsclk_sel, ls_active, hs_active,
                     switch_busy, timeout_err}),
          32'(exp_q.pop_front()));
  end

  function automatic logic pick(input int w);
    case (w)
      0:       return hsclk_sel;
      1:       return ls_active;
      2:       return hs_active;
      3:       return switch_busy;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic v, input int maxc,
                          output int cnt);
    cnt = 0;
    while (pick(w) !== v && cnt < maxc) begin
      @(negedge hsclk_in);
      cnt++;
    end
    chk($sformatf("wait%0d", w), 32'(pick(w)), 32'(v));
  endtask

  task automatic async_reset(input string tag);
    @(posedge hsclk_in);
    #2 rst_b = 1'b0;
    #1;
    chk({tag, "_sel"}, 32'(hsclk_sel), 0);
    chk({tag, "_ls"}, 32'(ls_active), 1);
    chk({tag, "_busy"}, 32'(switch_busy), 0);
    chk({tag, "_err"}, 32'(timeout_err), 0);
    @(negedge hsclk_in);
    #1 rst_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge hsclk_in);
    chk("rst_sel", 32'(hsclk_sel), 0);
    chk("rst_ls", 32'(ls_active), 1);
    #1 rst_b = 1'b1;

    // Holdoff countdown then HS handshake
    wait_sig(0, 1'b1, 20, n);
    chk("t1_sel_rise", n, 5);
    wait_sig(2, 1'b1, 20, n);
    chk("t1_hs_lat", n, 6);

    // One-cycle host access pulse
    host_access_req = 1'b1;
    @(negedge hsclk_in);
    host_access_req = 1'b0;
    chk("t2_sel_fall", 32'(hsclk_sel), 0);
    chk("t2_busy", 32'(switch_busy), 1);
    wait_sig(1, 1'b1, 30, n);
    chk("t2_ls_lat", n, 6);
    wait_sig(0, 1'b1, 20, n);
    chk("t2_holdoff", n, 5);

    // Demand reverses during TO_HS: no abort
    host_access_req = 1'b1;
    wait_sig(2, 1'b1, 20, n);
    chk("t3_hs_lat", n, 6);
    @(negedge hsclk_in);
    chk("t3_hs_one", 32'(hs_active), 0);
    chk("t3_sel", 32'(hsclk_sel), 0);
    wait_sig(1, 1'b1, 20, n);
    repeat (10) @(negedge hsclk_in);
    chk("t3_hold_ls", 32'(hsclk_sel), 0);
    host_access_req = 1'b0;

    // hs_allow gating
    hs_allow = 1'b0;
    repeat (30) @(negedge hsclk_in);
    chk("t5_no_hs", 32'(hsclk_sel), 0);
    hs_allow = 1'b1;
    wait_sig(2, 1'b1, 40, n);
    chk("t5_hs_lat", n, 11);
    ctl_drop = 1'b1;
    repeat (8) @(negedge hsclk_in);
    chk("hs_ackloss", 32'(hs_active), 1);
    ctl_drop = 1'b0;
    hs_allow = 1'b0;
    @(negedge hsclk_in);
    chk("t5_drop", 32'(hsclk_sel), 0);
    wait_sig(1, 1'b1, 30, n);

    // Timeout with a silent controller
    ctl_mute = 1'b1;
    hs_allow = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    wait_sig(4, 1'b1, 400, n);
    chk("t4_to_lat", n, TMO);
    chk("t4_sel", 32'(hsclk_sel), 1);
    repeat (5) @(negedge hsclk_in);
    chk("t4_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge hsclk_in);
    err_clr = 1'b0;
    chk("t4_clr", 32'(timeout_err), 0);
    repeat (5) @(negedge hsclk_in);
    chk("t4_no_retrig", 32'(timeout_err), 0);

    // Reset mid-switch, then clear colliding with timeout
    async_reset("t6");
    wait_sig(0, 1'b1, 20, n);
    chk("t6_sel_rise", n, 5);
    repeat (TMO - 1) @(negedge hsclk_in);
    chk("t4_pre", 32'(timeout_err), 0);
    err_clr = 1'b1;
    @(negedge hsclk_in);
    err_clr = 1'b0;
    chk("t4_set_wins", 32'(timeout_err), 1);

    // Overlapping acks are not an acknowledge
    async_reset("t6b");
    ctl_mute = 1'b0;
    ctl_both = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    repeat (15) @(negedge hsclk_in);
    chk("ovl_busy", 32'(switch_busy), 1);
    chk("ovl_hs", 32'(hs_active), 0);
    ctl_both = 1'b0;
    wait_sig(2, 1'b1, 10, n);
    chk("ovl_hs_lat", n, 3);

    repeat (3) @(negedge hsclk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
